// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Registered, handshaked ALU execute stage. It decodes ALUOp/funct_field
//   into a 4-bit operation, computes the result on a WIDTH-bit datapath and
//   holds it in a valid/ready output register that downstream may stall.
//
//   Optional feature macro: ALU_MULT_EN
//     defined   : funct 011000 selects an iterative shift-add multiply that
//                 takes WIDTH cycles in the BUSY state.
//     undefined : funct 011000 decodes as add; every op has latency 1 and
//                 the multiply datapath is not built.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   ALUOp        00 LW/SW, 01 branch equal, 10 R-type, 11 treated as add
//   funct_field  R-type funct (used only when ALUOp = 10)
//   a, b         operands
//   in_valid     request present
//   in_ready     request accepted when in_valid & in_ready at a clk edge
//   result       registered result
//   zero         registered (result == 0)
//   operation    registered decoded operation that produced result
//   out_valid    result/zero/operation valid
//   out_ready    consumer takes the output when out_valid & out_ready
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct_field,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [3:0]       operation,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef ALU_MULT_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
`endif

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // ALU control decode; every unlisted encoding falls back to add.
  function automatic logic [3:0] decode_op(input logic [1:0] alu_op,
                                           input logic [5:0] funct);
    logic [3:0] op;
    op = OP_ADD;
    case (alu_op)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        case (funct[3:0])
          4'b0000: op = OP_ADD;
          4'b0010: op = OP_SUB;
          4'b0100: op = OP_AND;
          4'b0101: op = OP_OR;
          4'b0111: op = OP_NOR;
          4'b1010: op = OP_SLT;
          default: op = OP_ADD;
        endcase
`ifdef ALU_MULT_EN
        // The multiply funct needs the full 6 bits; its low nibble is unused above.
        if (funct == 6'b011000) begin
          op = OP_MUL;
        end else begin
          op = op;
        end
`endif
      end
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

  // Single-cycle datapath; the multiply encoding never reaches here.
  function automatic logic [WIDTH-1:0] alu_compute(input logic [3:0]       op,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] res;
    case (op)
      OP_AND:  res = x & y;
      OP_OR:   res = x | y;
      OP_ADD:  res = x + y;
      OP_SUB:  res = x - y;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_NOR:  res = ~(x | y);
      default: res = x + y;
    endcase
    return res;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       w_op;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_accept;
  logic             w_wr;
  logic [WIDTH-1:0] w_wr_data;
  logic [3:0]       w_wr_op;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [3:0]       r_operation;
  logic             r_out_valid;

  assign w_op      = decode_op(ALUOp, funct_field);
  assign w_alu_res = alu_compute(w_op, a, b);

  // Accept only in IDLE and only if the output slot is empty or draining now.
  assign in_ready = (r_state == S_IDLE) & (~r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;

`ifdef ALU_MULT_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_acc_step;

  assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Shift-add multiply registers: load on a mul accept, one step per BUSY cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= {WIDTH{1'b0}};
      r_mcand  <= {WIDTH{1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if ((r_state == S_IDLE) && w_accept && (w_op == OP_MUL)) begin
      r_acc    <= {WIDTH{1'b0}};
      r_mcand  <= a;
      r_mplier <= b;
      r_count  <= CW'(WIDTH);
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_acc_step;
      r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_count  <= r_count - CW'(1);
    end else begin
      r_acc    <= r_acc;
      r_mcand  <= r_mcand;
      r_mplier <= r_mplier;
      r_count  <= r_count;
    end
  end
`else
  // funct[5:4] only matter to the multiply decode, which is absent here.
  logic w_unused_funct;
  assign w_unused_funct = &{1'b0, funct_field[5:4]};
`endif

  // Next-state and output-register write control.
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_wr_data   = w_alu_res;
    w_wr_op     = w_op;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef ALU_MULT_EN
          if (w_op == OP_MUL) begin
            w_state_nxt = S_BUSY;
          end else begin
            w_wr = 1'b1;
          end
`else
          w_wr = 1'b1;
`endif
        end else begin
          w_wr = 1'b0;
        end
      end
      S_BUSY: begin
`ifdef ALU_MULT_EN
        // The final step's sum goes straight to the output register.
        if (r_count == CW'(1)) begin
          w_wr        = 1'b1;
          w_wr_data   = w_acc_step;
          w_wr_op     = OP_MUL;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BUSY;
        end
`else
        w_state_nxt = S_IDLE;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output register; a write wins over a same-edge consume so data streams.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result    <= {WIDTH{1'b0}};
      r_zero      <= 1'b1;
      r_operation <= OP_ADD;
      r_out_valid <= 1'b0;
    end else if (w_wr) begin
      r_result    <= w_wr_data;
      r_zero      <= (w_wr_data == {WIDTH{1'b0}});
      r_operation <= w_wr_op;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign result    = r_result;
  assign zero      = r_zero;
  assign operation = r_operation;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//   Self-checking bench for alu_exec_unit (WIDTH = 32). Expected results are
//   queued when a request is driven; a monitor records every consumed output
//   and each test task pops and compares both queues. Multiply scenarios are
//   selected with ALU_MULT_EN, matching the design build.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   ALUOp;
  logic [5:0]   funct_field;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] result;
  logic         zero;
  logic [3:0]   operation;
  logic         out_valid;
  logic         out_ready;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   op;
    logic         z;
  } item_t;

  item_t exp_q[$];
  item_t got_q[$];
  int    checks   = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .ALUOp       (ALUOp),
    .funct_field (funct_field),
    .a           (a),
    .b           (b),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .result      (result),
    .zero        (zero),
    .operation   (operation),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  // Record every output that will be consumed at the coming rising edge.
  always begin
    item_t g;
    @(negedge clk);
    #2;
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      g.res = result;
      g.op  = operation;
      g.z   = zero;
      got_q.push_back(g);
    end
  end

  // Present one request (called at a falling edge), wait for acceptance,
  // then return at the following falling edge with in_valid dropped.
  task automatic send(input logic [1:0] op, input logic [5:0] f,
                      input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic [W-1:0] er, input logic [3:0] eo);
    item_t it;
    int    n;
    logic  acc;
    ALUOp = op; funct_field = f; a = aa; b = bb; in_valid = 1'b1;
    it.res = er; it.op = eo; it.z = (er == {W{1'b0}});
    exp_q.push_back(it);
    n = 0; acc = 1'b0;
    while (!acc && n < 200) begin
      #1;
      acc = (in_ready === 1'b1);
      @(posedge clk);
      if (!acc) @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_accept: request not accepted within %0d cycles (expected acceptance)", n);
    end
  endtask

  // Wait (bounded) until at least n outputs were recorded; returns at a falling edge.
  task automatic wait_out(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 200) begin
      @(negedge clk);
      #3;
      k++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ALUOp = 2'b00; funct_field = 6'b000000; a = {W{1'b0}}; b = {W{1'b0}};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_q.delete(); got_q.delete();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (result !== {W{1'b0}}) begin failures++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero: got %b expected 1", zero); end
    checks++; if (operation !== 4'b0010) begin failures++; $display("FAIL reset_operation: got %b expected 0010", operation); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_decode();
    item_t e, g;
    out_ready = 1'b1;
    send(2'b00, 6'b000000, 32'd5, 32'd3, 32'd8, 4'b0010);
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL decode_latency: out_valid=%b expected 1 one cycle after accept", out_valid); end
    send(2'b01, 6'b000000, 32'd5, 32'd5, 32'd0, 4'b0110);
    send(2'b10, 6'b000010, 32'd9, 32'd4, 32'd5, 4'b0110);
    send(2'b10, 6'b000000, 32'd9, 32'd4, 32'd13, 4'b0010);
    send(2'b11, 6'b111111, 32'd2, 32'd3, 32'd5, 4'b0010);
    send(2'b10, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'b0000);
    send(2'b10, 6'b100101, 32'h0000_F0F0, 32'h0000_0F00, 32'h0000_FFF0, 4'b0001);
    send(2'b10, 6'b000001, 32'd10, 32'd20, 32'd30, 4'b0010);
    wait_out(8);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
        failures++; $display("FAIL decode[%0d]: missing output (got %0d queued, expected %0d)", i, got_q.size(), exp_q.size());
      end else begin
        e = exp_q.pop_front(); g = got_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL decode[%0d]: got res=%h op=%b zero=%b expected res=%h op=%b zero=%b", i, g.res, g.op, g.z, e.res, e.op, e.z);
        end
      end
    end
  endtask

  task automatic test_slt_nor();
    item_t e, g;
    out_ready = 1'b1;
    send(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0111);
    send(2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'b0111);
    send(2'b10, 6'b100111, 32'd0, 32'd0, 32'hFFFF_FFFF, 4'b1100);
    wait_out(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
        failures++; $display("FAIL slt_nor[%0d]: missing output (got %0d queued, expected %0d)", i, got_q.size(), exp_q.size());
      end else begin
        e = exp_q.pop_front(); g = got_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL slt_nor[%0d]: got res=%h op=%b zero=%b expected res=%h op=%b zero=%b", i, g.res, g.op, g.z, e.res, e.op, e.z);
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    item_t e, g;
    out_ready = 1'b0;
    send(2'b00, 6'b000000, 32'd1, 32'd2, 32'd3, 4'b0010);
    ALUOp = 2'b00; funct_field = 6'b000000; a = 32'd10; b = 32'd20; in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready); end
      checks++; if (out_valid !== 1'b1 || result !== 32'd3) begin failures++; $display("FAIL bp_hold[%0d]: got valid=%b res=%h expected valid=1 res=3", c, out_valid, result); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(2'b00, 6'b000000, 32'd10, 32'd20, 32'd30, 4'b0010);
    send(2'b00, 6'b000000, 32'd100, 32'd200, 32'd300, 4'b0010);
    wait_out(3);
    repeat (3) @(negedge clk);
    checks++; if (got_q.size() != 3) begin failures++; $display("FAIL bp_count: got %0d outputs expected 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
        failures++; $display("FAIL bp_order[%0d]: missing output (got %0d queued, expected %0d)", i, got_q.size(), exp_q.size());
      end else begin
        e = exp_q.pop_front(); g = got_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL bp_order[%0d]: got res=%h op=%b zero=%b expected res=%h op=%b zero=%b", i, g.res, g.op, g.z, e.res, e.op, e.z);
        end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

`ifdef ALU_MULT_EN
  task automatic test_mul();
    item_t e, g;
    int    cnt;
    int    hi;
    out_ready = 1'b1;
    send(2'b10, 6'b011000, 32'd7, 32'd6, 32'd42, 4'b1000);
    cnt = 0; hi = 0;
    while (cnt < 100) begin
      #1;
      if (out_valid === 1'b1) break;
      if (in_ready !== 1'b0) hi++;
      cnt++;
      @(negedge clk);
    end
    checks++; if (cnt != 32) begin failures++; $display("FAIL mul_latency: out_valid after %0d busy cycles expected 32", cnt); end
    checks++; if (hi != 0) begin failures++; $display("FAIL mul_in_ready: in_ready high in %0d busy cycles expected 0", hi); end
    send(2'b10, 6'b011000, 32'h8000_0000, 32'd2, 32'd0, 4'b1000);
    wait_out(2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
        failures++; $display("FAIL mul[%0d]: missing output (got %0d queued, expected %0d)", i, got_q.size(), exp_q.size());
      end else begin
        e = exp_q.pop_front(); g = got_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL mul[%0d]: got res=%h op=%b zero=%b expected res=%h op=%b zero=%b", i, g.res, g.op, g.z, e.res, e.op, e.z);
        end
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    item_t e, g;
    out_ready = 1'b1;
    send(2'b10, 6'b011000, 32'd3, 32'd3, 32'd9, 4'b1000);
    void'(exp_q.pop_back());
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    send(2'b00, 6'b000000, 32'd1, 32'd1, 32'd2, 4'b0010);
    #1;
    checks++; if (out_valid !== 1'b1 || result !== 32'd2) begin failures++; $display("FAIL abort_add: got valid=%b res=%h expected valid=1 res=2", out_valid, result); end
    wait_out(1);
    repeat (40) @(negedge clk);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL abort_count: got %0d outputs expected 1", got_q.size()); end
    checks++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin
      failures++; $display("FAIL abort_data: missing output (got %0d queued, expected %0d)", got_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin
        failures++;
        $display("FAIL abort_data: got res=%h op=%b zero=%b expected res=%h op=%b zero=%b", g.res, g.op, g.z, e.res, e.op, e.z);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask
`else
  task automatic test_mul_disabled();
    item_t e, g;
    out_ready = 1'b1;
    send(2'b10, 6'b011000, 32'd7, 32'd6, 32'd13, 4'b0010);
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL nomul_latency: out_valid=%b expected 1 one cycle after accept", out_valid); end
    wait_out(1);
    checks++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin
      failures++; $display("FAIL nomul_data: missing output (got %0d queued, expected %0d)", got_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin
        failures++;
        $display("FAIL nomul_data: got res=%h op=%b zero=%b expected res=%h op=%b zero=%b", g.res, g.op, g.z, e.res, e.op, e.z);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
    test_slt_nor();
    test_back_pressure();
`ifdef ALU_MULT_EN
    test_mul();
    test_reset_mid_mul();
`else
    test_mul_disabled();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered, handshaked ALU execute stage. It merges ALU control decode (ALUOp + funct_field → 4-bit operation) with a WIDTH-parametrised datapath, and adds an optional iterative multiply. It sits between the decode/register-read stage and writeback in the multi-cycle datapath. Results leave through a valid/ready output register, so the downstream stage may stall it.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high reset
- ALUOp  input  2  00 = LW/SW, 01 = branch equal, 10 = R-type, 11 = out of scope
- funct_field  input  6  R-type funct; used only when ALUOp = 10
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- in_valid  input  1  request present
- in_ready  output  1  request accepted when in_valid & in_ready at a clk edge
- result  output  WIDTH  registered result
- zero  output  1  registered, result == 0
- operation  output  4  registered decoded operation that produced result
- out_valid  output  1  result/zero/operation valid
- out_ready  input  1  consumer takes the output when out_valid & out_ready

## Operation
- Decode, combinational on the accepted request:
  - ALUOp 00 → 0010 (add).
  - ALUOp 01 → 0110 (sub).
  - ALUOp 11 → 0010 (add).
  - ALUOp 10 decodes funct_field[3:0]: 0000 → 0010 add; 0010 → 0110 sub; 0100 → 0000 and; 0101 → 0001 or; 0111 → 1100 nor; 1010 → 0111 slt.
  - With ALU_MULT_EN defined, funct_field = 011000 → 1000 mul.
  - Any other funct decodes as 0010 add.
- Arithmetic is modulo 2^WIDTH; overflow is not flagged. slt compares signed and yields {WIDTH-1 zeros, a<b}. mul yields the low WIDTH bits of the product.
- FSM states:
  - IDLE: accepts requests. Non-mul ops write the output register at the accepting edge. mul latches a and b, clears the accumulator, loads count = WIDTH, and moves to BUSY.
  - BUSY: one shift-add step per cycle (if multiplier LSB is set, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count--). When count reaches 0, writes acc to the output register and returns to IDLE.
- in_ready = (state == IDLE) & (!out_valid | out_ready).
- out_valid:
  - Set on an output-register write.
  - Cleared on a consume edge with no write in that edge.
  - If a consume and a write happen at the same edge, out_valid stays 1 and carries the new data.
- out_valid is always 0 throughout BUSY, because a mul is accepted only when the output is empty or draining.
- Output register holds stable while out_valid & !out_ready.
- Reset values: state IDLE, result 0, zero 1, operation 0010, out_valid 0, internal count/acc 0. Consequently in_ready = 1 in the first cycle after reset is released.
- Reset during BUSY aborts the multiply; no result is produced.

## Timing
- Non-mul latency is 1: output is valid in the cycle after the acceptance edge.
- Non-mul throughput is 1 per cycle while out_ready stays high.
- mul latency is WIDTH + 1 cycles from the acceptance edge to out_valid. in_ready is low for those WIDTH cycles.
- in_ready depends combinationally on out_ready. There is no other combinational input-to-output path.
- Back-pressure: with out_ready = 0 and out_valid = 1, in_ready = 0. No request is lost or duplicated.

## Configuration
- ALU_MULT_EN defined:
  - funct 011000 selects the iterative multiply.
  - BUSY state, counter and accumulator are present.
- ALU_MULT_EN undefined:
  - funct 011000 decodes as add (0010).
  - FSM never leaves IDLE; multiply logic is not synthesised.
  - Every op has latency 1.

## Test plan
- After reset: out_valid = 0, result = 0, zero = 1, operation = 0010, in_ready = 1.
- Decode and datapath: ALUOp = 00, a = 5, b = 3 → next cycle result = 8, operation = 0010.
  - ALUOp = 01, a = 5, b = 5 → result = 0, zero = 1, operation = 0110.
  - ALUOp = 10, funct = 000010 → operation = 0110.
  - ALUOp = 10, funct = 000000 → 0010.
  - ALUOp = 11 → 0010.
- slt and nor: ALUOp = 10, funct = 101010, a = 0xFFFFFFFF, b = 1 → result = 1.
  - funct = 100111, a = b = 0 → result = 0xFFFFFFFF, operation = 1100.
- Back-pressure: three back-to-back adds with out_ready held 0 for 4 cycles → first result is held stable and in_ready = 0. After release, three results come out in order, none dropped.
- Multiply (ALU_MULT_EN): a = 7, b = 6, WIDTH = 32 → in_ready low for 32 cycles, out_valid at cycle 33, result = 42, operation = 1000.
  - Also a = 0x80000000, b = 2 → result = 0.
- Reset mid-multiply at cycle 10 of BUSY → next cycle state is IDLE, out_valid = 0, in_ready = 1. A following add of 1 + 1 returns 2 after 1 cycle.
  - Without ALU_MULT_EN, funct 011000 with a = 7, b = 6 → result = 13 after 1 cycle.
